// File: rtl/lsu_apb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : RV32I load/store size codes and LSU APB state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_apb_master_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_apb_master_if
// Description : APB requester/completer signal bundle for the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_apb_master_if #(
  parameter int ADDR_W = 12
) ();

  logic [ADDR_W-1:0] paddr_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [31:0]       pwdata_o;
  logic [3:0]        pstrb_o;
  logic [31:0]       prdata_i;
  logic              pready_i;

  modport master (
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  prdata_i, pready_i
  );

  modport slave (
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output prdata_i, pready_i
  );

endinterface
`default_nettype wire

// File: rtl/lsu_apb_master_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Store lane/strobe generation, legality check, load extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wlane_o,
  output logic        illegal_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] w_shifted;

  always_comb begin
    strb_o  = 4'b0000;
    wlane_o = 32'h0000_0000;
    if (we_i) begin
      case (funct3_i)
        SB: begin
          strb_o  = 4'b0001 << addr_lo_i;
          wlane_o = {4{wdata_i[7:0]}};
        end
        SH: begin
          strb_o  = 4'b0011 << {addr_lo_i[1], 1'b0};
          wlane_o = {2{wdata_i[15:0]}};
        end
        SW: begin
          strb_o  = 4'b1111;
          wlane_o = wdata_i;
        end
        default: ;
      endcase
    end
  end

  // funct3[1:0] is the access size for both loads and stores
  always_comb begin
    illegal_o = 1'b0;
    case (funct3_i)
      3'b011, 3'b110, 3'b111: illegal_o = 1'b1;
      default: ;
    endcase
    if (funct3_i[1:0] == 2'b01 && addr_lo_i[0])
      illegal_o = 1'b1;
    if (funct3_i[1:0] == 2'b10 && addr_lo_i != 2'b00)
      illegal_o = 1'b1;
    if (we_i && funct3_i[2])
      illegal_o = 1'b1;
  end

  assign w_shifted = ld_word_i >> {ld_addr_lo_i, 3'b000};

  always_comb begin
    case (ld_funct3_i)
      LB:      ld_data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LBU:     ld_data_o = {24'h00_0000, w_shifted[7:0]};
      LH:      ld_data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LHU:     ld_data_o = {16'h0000, w_shifted[15:0]};
      LW:      ld_data_o = w_shifted;
      default: ld_data_o = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_apb_master
// Description : RV32I load/store unit issuing single APB transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_apb_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [2:0]        funct3_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  lsu_apb_master_if.master  apb
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_paddr;
  logic [31:0]       r_pwdata;
  logic [3:0]        r_pstrb;
  logic              r_pwrite;
  logic [2:0]        r_funct3;
  logic [31:0]       r_rdata;
  logic              r_done;
  logic              r_err;

  logic [3:0]        w_strb;
  logic [31:0]       w_wlane;
  logic [31:0]       w_ld_data;
  logic              w_illegal;
  logic              w_accept;
  logic              w_complete;
  logic              w_busy;
  logic              w_psel;
  logic              w_penable;
  logic              w_unused;

  assign w_unused = ^addr_i[31:ADDR_W];

  lsu_align u_align (
    .we_i         (we_i),
    .funct3_i     (funct3_i),
    .addr_lo_i    (addr_i[1:0]),
    .wdata_i      (wdata_i),
    .strb_o       (w_strb),
    .wlane_o      (w_wlane),
    .illegal_o    (w_illegal),
    .ld_funct3_i  (r_funct3),
    .ld_addr_lo_i (r_paddr[1:0]),
    .ld_word_i    (apb.prdata_i),
    .ld_data_o    (w_ld_data)
  );

  assign w_accept   = (r_state == ST_IDLE) && req_i && !w_illegal;
  assign w_complete = (r_state == ST_ACCESS) && apb.pready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (req_i && !w_illegal) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (apb.pready_i) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = 1'b0;
    w_psel    = 1'b0;
    w_penable = 1'b0;
    case (r_state)
      ST_SETUP: begin
        w_busy = 1'b1;
        w_psel = 1'b1;
      end
      ST_ACCESS: begin
        w_busy    = 1'b1;
        w_psel    = 1'b1;
        w_penable = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are frozen at acceptance so the bus stays stable through wait states
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_paddr  <= '0;
      r_pwdata <= 32'h0000_0000;
      r_pstrb  <= 4'b0000;
      r_pwrite <= 1'b0;
      r_funct3 <= 3'b000;
      r_rdata  <= 32'h0000_0000;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_complete;
      r_err  <= (r_state == ST_IDLE) && req_i && w_illegal;
      if (w_accept) begin
        r_paddr  <= addr_i[ADDR_W-1:0];
        r_pwdata <= w_wlane;
        r_pstrb  <= w_strb;
        r_pwrite <= we_i;
        r_funct3 <= funct3_i;
      end
      if (w_complete)
        r_rdata <= r_pwrite ? 32'h0000_0000 : w_ld_data;
    end
  end

  assign busy_o        = w_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign rdata_o       = r_rdata;
  assign apb.paddr_o   = r_paddr;
  assign apb.psel_o    = w_psel;
  assign apb.penable_o = w_penable;
  assign apb.pwrite_o  = r_pwrite;
  assign apb.pwdata_o  = r_pwdata;
  assign apb.pstrb_o   = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_lsu_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_apb_master
// Description : Scoreboard bench for lsu_apb_master with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_apb_master;
  import lsu_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [2:0]  funct3_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;

  lsu_apb_master_if #(.ADDR_W(12)) apb ();

  lsu_apb_master #(.ADDR_W(12)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .funct3_i (funct3_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .apb      (apb)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [11:0] paddr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_exp_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_exp_t;

  apb_exp_t apb_q[$];
  rsp_exp_t rsp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: completed APB accesses and done/err pulses are matched in order
  always @(negedge clk_i) begin : mon
    apb_exp_t ea;
    rsp_exp_t er;
    if (apb.psel_o && apb.penable_o && apb.pready_i) begin
      if (apb_q.size() == 0) begin
        check("apb_unexpected", 32'd1, 32'd0);
      end else begin
        ea = apb_q.pop_front();
        check("apb_paddr", {20'h0, apb.paddr_o}, {20'h0, ea.paddr});
        check("apb_pwrite", {31'h0, apb.pwrite_o}, {31'h0, ea.write});
        check("apb_pstrb", {28'h0, apb.pstrb_o}, {28'h0, ea.strb});
        if (ea.write)
          check("apb_pwdata", apb.pwdata_o, ea.wdata);
      end
    end
    if (done_o || err_o) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", {30'h0, done_o, err_o}, 32'd0);
      end else begin
        er = rsp_q.pop_front();
        check("rsp_err", {31'h0, err_o}, {31'h0, er.err});
        check("rsp_done", {31'h0, done_o}, {31'h0, !er.err});
        if (!er.err)
          check("rsp_rdata", rdata_o, er.rdata);
      end
    end
  end

  // Drives one request (caller is at a negedge) and returns at the done/err negedge
  task automatic issue(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3, input logic [31:0] prdata,
                       input logic exp_err, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    int k;
    bit seen;
    apb_exp_t ea;
    rsp_exp_t er;
    if (!exp_err) begin
      ea.paddr = addr[11:0];
      ea.write = we;
      ea.wdata = exp_wdata;
      ea.strb  = exp_strb;
      apb_q.push_back(ea);
    end
    er.err   = exp_err;
    er.rdata = exp_rdata;
    rsp_q.push_back(er);
    req_i        = 1'b1;
    we_i         = we;
    addr_i       = addr;
    wdata_i      = wdata;
    funct3_i     = f3;
    apb.prdata_i = prdata;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk_i);
      k++;
      if (exp_err)
        check({name, "_nobus"}, {30'h0, apb.psel_o, busy_o}, 32'd0);
      else if (k < 3)
        check({name, "_phase"}, {29'h0, busy_o, apb.psel_o, apb.penable_o},
              (k == 1) ? 32'd6 : 32'd7);
      seen = done_o || err_o;
    end
    check({name, "_lat"}, k, exp_err ? 32'd1 : 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni       = 1'b0;
    req_i        = 1'b0;
    we_i         = 1'b0;
    addr_i       = 32'h0;
    wdata_i      = 32'h0;
    funct3_i     = 3'b000;
    apb.prdata_i = 32'h0;
    apb.pready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_ctrl", {26'h0, apb.psel_o, apb.penable_o, apb.pwrite_o, busy_o, done_o, err_o}, 32'd0);
    check("rst_paddr", {20'h0, apb.paddr_o}, 32'd0);
    check("rst_pwdata", apb.pwdata_o, 32'd0);
    check("rst_pstrb", {28'h0, apb.pstrb_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    //     name      we    addr           wdata          f3      prdata         err   strb   exp_wdata      exp_rdata
    issue("sw",      1'b1, 32'h0000_0010, 32'hDEADBEEF,  SW,     32'h0,         1'b0, 4'hF,  32'hDEADBEEF,  32'h0);
    issue("sb",      1'b1, 32'h0000_0013, 32'h0000_00A5, SB,     32'h0,         1'b0, 4'h8,  32'hA5A5A5A5,  32'h0);
    issue("lb",      1'b0, 32'h0000_0013, 32'h0,         LB,     32'h80FF1234,  1'b0, 4'h0,  32'h0,         32'hFFFFFF80);
    issue("lbu",     1'b0, 32'h0000_0013, 32'h0,         LBU,    32'h80FF1234,  1'b0, 4'h0,  32'h0,         32'h00000080);
    issue("lh",      1'b0, 32'h0000_0012, 32'h0,         LH,     32'h9ABC0000,  1'b0, 4'h0,  32'h0,         32'hFFFF9ABC);
    issue("lw_mis",  1'b0, 32'h0000_0006, 32'h0,         LW,     32'h0,         1'b1, 4'h0,  32'h0,         32'h0);
    check("rdata_hold_err", rdata_o, 32'hFFFF9ABC);
    issue("lhu",     1'b0, 32'h0000_0002, 32'h0,         LHU,    32'h87654321,  1'b0, 4'h0,  32'h0,         32'h00008765);
    issue("lw_hi",   1'b0, 32'hFFFF_F124, 32'h0,         LW,     32'hCAFEF00D,  1'b0, 4'h0,  32'h0,         32'hCAFEF00D);
    issue("sh_hi",   1'b1, 32'h0000_001E, 32'h0000_BEEF, SH,     32'h0,         1'b0, 4'hC,  32'hBEEFBEEF,  32'h0);
    issue("sb_l1",   1'b1, 32'h0000_0011, 32'h0000_003C, SB,     32'h0,         1'b0, 4'h2,  32'h3C3C3C3C,  32'h0);
    issue("lb_pos",  1'b0, 32'h0000_0001, 32'h0,         LB,     32'h00007F00,  1'b0, 4'h0,  32'h0,         32'h0000007F);
    issue("st_f3_4", 1'b1, 32'h0000_0000, 32'h0000_0001, 3'b100, 32'h0,         1'b1, 4'h0,  32'h0,         32'h0);
    issue("f3_3",    1'b0, 32'h0000_0000, 32'h0,         3'b011, 32'h0,         1'b1, 4'h0,  32'h0,         32'h0);
    issue("sh_mis",  1'b1, 32'h0000_0015, 32'h0,         SH,     32'h0,         1'b1, 4'h0,  32'h0,         32'h0);
    issue("lh_mis",  1'b0, 32'h0000_0003, 32'h0,         LH,     32'h0,         1'b1, 4'h0,  32'h0,         32'h0);
    issue("f3_6",    1'b0, 32'h0000_0000, 32'h0,         3'b110, 32'h0,         1'b1, 4'h0,  32'h0,         32'h0);
    repeat (3) @(negedge clk_i);
    check("rdata_hold_idle", rdata_o, 32'h0000007F);

    // Stalled access, then reset in the middle of the wait
    apb.pready_i = 1'b0;
    req_i    = 1'b1;
    we_i     = 1'b1;
    addr_i   = 32'h0000_0022;
    wdata_i  = 32'h1234_5678;
    funct3_i = SH;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    @(negedge clk_i);
    check("wait_setup", {29'h0, busy_o, apb.psel_o, apb.penable_o}, 32'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("wait_ctrl", {29'h0, busy_o, apb.psel_o, apb.penable_o}, 32'd7);
      check("wait_paddr", {20'h0, apb.paddr_o}, 32'h022);
      check("wait_pstrb", {28'h0, apb.pstrb_o}, 32'hC);
      check("wait_pwdata", apb.pwdata_o, 32'h56785678);
      check("wait_pwrite", {31'h0, apb.pwrite_o}, 32'd1);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_ctrl", {28'h0, apb.psel_o, apb.penable_o, busy_o, done_o}, 32'd0);
    check("arst_bus", {apb.pstrb_o, apb.paddr_o, 15'h0, apb.pwrite_o}, 32'd0);
    check("arst_pwdata", apb.pwdata_o, 32'd0);
    check("arst_rdata", rdata_o, 32'd0);
    apb.pready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("post_rst_quiet", {29'h0, done_o, busy_o, apb.psel_o}, 32'd0);
    end

    issue("sw_after", 1'b1, 32'h0000_0100, 32'h0BADF00D, SW, 32'h0, 1'b0, 4'hF, 32'h0BADF00D, 32'h0);
    repeat (2) @(negedge clk_i);
    check("apb_q_empty", apb_q.size(), 32'd0);
    check("rsp_q_empty", rsp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_apb_master.md
LSU_APB_MASTER -- requirements
Module: lsu_apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the APB byte-address width driven on paddr_o.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port req_i  input  1  core load/store request, sampled only in IDLE.
REQ-005 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-006 SHALL have port addr_i  input  32  byte address; bits [ADDR_W-1:0] are forwarded.
REQ-007 SHALL have port wdata_i  input  32  store data, right-aligned.
REQ-008 SHALL have port funct3_i  input  3  RV32I size/sign code.
REQ-009 SHALL have port busy_o  output  1  high whenever state is not IDLE; the core stalls on it.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse when a transfer completes.
REQ-011 SHALL have port rdata_o  output  32  extended load result, valid while done_o is high.
REQ-012 SHALL have port err_o  output  1  one-cycle pulse on a misaligned access or invalid funct3.
REQ-013 SHALL have ports paddr_o [ADDR_W-1:0], psel_o, penable_o, pwrite_o, pwdata_o [31:0] and pstrb_o [3:0]  output  APB requester signals.
REQ-014 SHALL have ports prdata_i [31:0] and pready_i [1]  input  APB completer responses.

Function
REQ-015 SHALL implement a state machine with states IDLE, SETUP and ACCESS.
REQ-016 In IDLE, with req_i=1 and a legal request, SHALL latch the address, write lane data, strobe, we_i and funct3_i, then go to SETUP.
REQ-017 In IDLE, with req_i=1 and an illegal request, SHALL pulse err_o the next cycle, stay in IDLE and issue no APB transfer.
REQ-018 Illegal requests SHALL be: funct3 011, 110 or 111; halfword with addr[0]=1; word with addr[1:0]!=0; any store with funct3 100 or 101.
REQ-019 SETUP SHALL drive psel_o=1, penable_o=0 and go unconditionally to ACCESS.
REQ-020 ACCESS SHALL drive psel_o=1, penable_o=1.
REQ-021 ACCESS SHALL go to IDLE on pready_i=1; otherwise it SHALL remain in ACCESS indefinitely.
REQ-022 paddr_o, pwrite_o, pwdata_o and pstrb_o SHALL come from registers and stay constant from SETUP until ACCESS completes.
REQ-023 Store strobes SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-024 pwdata_o SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH and wdata for SW.
REQ-025 For loads, pstrb_o SHALL be 4'b0000.
REQ-026 In the cycle after ACCESS completes with pready_i=1, done_o SHALL be 1.
REQ-027 In that same cycle, rdata_o SHALL be prdata_i captured at completion, shifted right by 8*addr[1:0], then extended.
REQ-028 Extension SHALL be: LB sign-extended 8 bits, LBU zero-extended 8, LH sign-extended 16, LHU zero-extended 16, LW unchanged.
REQ-029 For a store, rdata_o SHALL be 0 while done_o is high.
REQ-030 Minimum latency SHALL be: req_i sampled in cycle N, SETUP N+1, ACCESS N+2, done_o N+3 with zero wait states.
REQ-031 A new req_i SHALL be accepted in the done_o cycle, since the state is already IDLE.
REQ-032 req_i while busy_o=1 SHALL be ignored; the core holds it.
REQ-033 rdata_o SHALL hold its value between transfers.

Reset
REQ-034 rst_ni=0 SHALL force IDLE asynchronously, including mid-SETUP or mid-ACCESS, abandoning the transfer.
REQ-035 On reset, psel_o, penable_o, pwrite_o, busy_o, done_o and err_o SHALL be 0.
REQ-036 On reset, paddr_o, pwdata_o, pstrb_o and rdata_o SHALL be 0.
REQ-037 A transfer aborted by reset SHALL not produce done_o.

Structure
REQ-038 Package lsu_pkg SHALL hold the funct3 encoding constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum type.
REQ-039 A combinational sub-module lsu_align SHALL compute strobe, write lane data, the misalign/illegal flag and load extraction/extension.
REQ-040 lsu_apb_master SHALL instantiate lsu_align exactly once.

Verification
REQ-041 SW addr=0x010, wdata=0xDEADBEEF, pready_i=1 -> pstrb=1111, pwdata=0xDEADBEEF, psel/penable sequence over 2 cycles, done_o at N+3.
REQ-042 SB addr=0x013, wdata=0x000000A5 -> pstrb=1000, pwdata=0xA5A5A5A5.
REQ-043 LB addr=0x013 then LBU at the same address, prdata_i=0x80FF1234 -> rdata_o=0xFFFFFF80, then 0x00000080.
REQ-044 LH addr=0x012, prdata_i=0x9ABC0000 -> rdata_o=0xFFFF9ABC.
REQ-045 LW addr=0x006 -> err_o pulse at N+1, psel_o never asserted, busy_o stays 0.
REQ-046 pready_i held low 5 cycles in ACCESS -> APB outputs stable and busy_o=1 throughout; rst_ni pulsed low during the wait -> psel_o=0 immediately and no done_o.
